// File: rtl/serial_rx_pkg.sv
// Shared serial-link types: receiver FSM states and the idle line level.
// Also intended for the serial transmitter block.
package serial_rx_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; 2 clk latency, no backpressure.
// Reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_8bit.sv
// Oversampling serial frame receiver; byte appears 1 clk after the mid-stop sample (+2 clk sync).
// Bytes held on rx_valid until rx_ready; a byte completing while one is still held is dropped and flagged sticky overrun.
module serial_rx_8bit
  import serial_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun,
  input  logic                 clear_err,
  output logic                 busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  rx_state_t              state;
  logic [OSW-1:0]         os_cnt;
  logic [BCW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shift_next;
  logic                   line;
  logic                   os_last;
  logic                   complete;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (line)
  );

  always_comb begin
    shift_next = shreg;
    if (MSB_FIRST) begin
      shift_next    = shreg << 1;
      shift_next[0] = line;
    end else begin
      shift_next                = shreg >> 1;
      shift_next[DATA_BITS-1]   = line;
    end
  end

  assign os_last  = (os_cnt == OS_LAST);
  assign complete = sample_tick && (state == RX_STOP) && os_last && (line == LINE_IDLE);
  assign busy     = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RX_IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;

      if (sample_tick) begin
        case (state)
          RX_IDLE: begin
            if (line != LINE_IDLE) begin
              state  <= RX_START;
              os_cnt <= '0;
            end
          end
          RX_START: begin
            // Re-check the line mid start bit to reject short glitches.
            if (os_cnt == OS_MID) begin
              if (line == LINE_IDLE) begin
                state <= RX_IDLE;
              end else begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                state   <= RX_DATA;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (os_last) begin
              os_cnt  <= '0;
              shreg   <= shift_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= RX_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (os_last) begin
              os_cnt <= '0;
              state  <= RX_IDLE;
              if (line != LINE_IDLE) frame_error <= 1'b1;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end

      // Clear first so a same-clk overrun set wins.
      if (clear_err) overrun <= 1'b0;

      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
